task_sequencer: RTL and testbench
=================================

// Module: task_sequencer
// PURPOSE
//  N-channel generalisation of the acquire/transmit dispatcher. Decodes command bytes from the UART receiver.
//  Grants exclusive control to one task unit at a time (acquisition, transmit, future channels), in index order.
//  Each grant waits for that unit's done pulse or a watchdog timeout. Runs continuously or as a single pass.
//  Sits between uart_rx and the task units; led shows run state.
// PARAMETERS
//  N_TASKS    2      number of task channels; 1..8
//  CMD_START  8'd98  rx byte that starts sequencing ('b')
//  CMD_STOP   8'd115 rx byte that requests stop ('s')
//  ONESHOT    0      0: wrap from last enabled task to first forever; 1: stop after one pass
//  TIMEOUT    1000   max cycles a grant may stay high waiting for done; 0 disables watchdog
//  TO_W       16     watchdog counter width; TIMEOUT < 2**TO_W
// PORTS
//  clk            in   1        system clock, all logic on posedge
//  rst            in   1        synchronous, active-high reset
//  rx_data_fresh  in   1        rx_data valid this cycle (level, may stay high several cycles)
//  rx_data        in   8        received command byte
//  task_en        in   N_TASKS  per-channel enable; disabled channels are skipped
//  done           in   N_TASKS  per-channel completion pulse, honoured only on the granted channel
//  grant          out  N_TASKS  one-hot (or zero) grant
//  cur_task       out  3        index of granted/last granted channel
//  led            out  1        1 while state != IDLE
//  timeout_flag   out  1        sticky; set when any grant times out, cleared by rst or next CMD_START
// BEHAVIOUR
//  Reset: state=IDLE, grant=0, cur_task=0, led=0, timeout_flag=0, stop_req=0, watchdog=0.
//  Command edge detect:
//   - a command is accepted on the first cycle rx_data_fresh is high after being low (registered previous value).
//   - a held-high fresh counts once; other byte values are ignored.
//  States: IDLE, SELECT, GRANT, GAP.
//   IDLE   : CMD_START -> clear timeout_flag and stop_req, cur_task=first enabled index, go SELECT.
//            CMD_START with no task_en bit set stays IDLE.
//   SELECT : assert grant[cur_task] next edge, go GRANT. Latency CMD_START accept -> grant high = 2 cycles.
//   GRANT  : grant held; watchdog counts up from 0.
//            done[cur_task] sampled 1 -> grant drops on that same edge, go GAP.
//            watchdog reaches TIMEOUT-1 with no done -> grant drops, timeout_flag=1, go GAP.
//            done of non-granted channels ignored.
//   GAP    : one idle cycle with grant=0; choose next enabled index above cur_task (wrap to lowest).
//            if stop_req, or ONESHOT and wrap would occur, or no channel enabled -> IDLE.
//            else cur_task=next, go SELECT.
//  Grant timing: done seen at edge k -> grant[i]=0 at k, grant[next]=1 at k+2 (GAP, SELECT).
//  CMD_STOP while not IDLE sets stop_req; current task is never aborted, sequencer idles at the following GAP.
//  CMD_STOP in IDLE is ignored.
//  CMD_START while running is ignored (no restart).
//  Simultaneous done and timeout expiry: treated as done, flag not set.
//  task_en changes take effect at the next GAP selection only; a granted channel keeps its grant if disabled mid-task.
//  Single-channel enabled: same channel regranted each pass with the GAP+SELECT bubble.
//  rst mid-GRANT: grant drops at that edge, all state as reset.
//  Invariant: popcount(grant) <= 1 every cycle.
// STRUCTURE
//  Shared include task_defs.vh: CMD_START/CMD_STOP byte constants, state encodings (IDLE..GAP), cur_task width.
//  Sub-module task_watchdog (clear, enable, TIMEOUT/TO_W params -> expired pulse): separable, reusable for uart_tx.
//  Next-index select is a combinational priority-rotate function kept in this file.
// TESTING
//  1 N=2, continuous, fresh=1 rx=98; each grant answered by done pulse 25 units later
//    -> grant alternates 01,10,01...; grant=0 exactly one cycle between; led=1.
//  2 Hold fresh high 5 cycles with rx=98
//    -> only one start; then send rx=115 during grant[1]
//    -> grant[1] completes, IDLE, led=0, no further grants.
//  3 N=4, task_en=4'b1010
//    -> grants only 0010,1000,0010...; cur_task sequence 1,3,1.
//  4 TIMEOUT=8, never pulse done[0]
//    -> grant[0] drops after 8 cycles; timeout_flag=1; grant[1] two cycles later; next start clears flag.
//  5 ONESHOT=1, N=3, all enabled -> grants 0,1,2 once, then IDLE; done on non-granted line has no effect.
//  6 Assert rst while grant[1]=1 -> grant=0, led=0 same edge; later rx=98 restarts from channel 0.

Source files
------------

// File: rtl/task_sequencer_pkg.sv
// Shared types and helpers for the task sequencer: command width, state encoding,
// channel index width and the next-channel selection record.
package task_sequencer_pkg;

  localparam int unsigned CMD_W     = 8;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned MAX_TASKS = 8;

  localparam logic [CMD_W-1:0] CMD_START_DEF = 8'd98;
  localparam logic [CMD_W-1:0] CMD_STOP_DEF  = 8'd115;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SELECT,
    ST_GRANT,
    ST_GAP
  } state_t;

  // Result of a next-channel search: any channel enabled, search wrapped, chosen index.
  typedef struct packed {
    logic             found;
    logic             wrap;
    logic [IDX_W-1:0] idx;
  } sel_t;

  function automatic logic [IDX_W-1:0] lowest_set(input logic [MAX_TASKS-1:0] v);
    lowest_set = '0;
    for (int i = MAX_TASKS - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = IDX_W'(i);
    end
  endfunction

endpackage

// File: rtl/task_sequencer_watchdog.sv
// Grant watchdog: counts enabled cycles and pulses expired_c on the TIMEOUT-th one.
// TIMEOUT of 0 disarms it; reusable for any single-owner wait.
module task_sequencer_watchdog #(
  parameter int unsigned TIMEOUT = 1000,
  parameter int unsigned TO_W    = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  localparam bit          ARMED = (TIMEOUT != 0);
  localparam int unsigned LIMIT = ARMED ? TIMEOUT - 1 : 0;

  logic [TO_W-1:0] count;

  assign expired_c = ARMED && enable && (count == TO_W'(LIMIT));

  // Restart from zero on clear or expiry so the next owner gets a full budget.
  always_ff @(posedge clk) begin
    if (rst || clear || expired_c) begin
      count <= '0;
    end else if (enable) begin
      count <= count + TO_W'(1);
    end
  end

endmodule

// File: rtl/task_sequencer.sv
// N-channel dispatcher: UART start/stop commands drive a round-robin over enabled
// task units, granting one at a time until done or watchdog expiry.
module task_sequencer
  import task_sequencer_pkg::*;
#(
  parameter int unsigned      N_TASKS   = 2,
  parameter logic [CMD_W-1:0] CMD_START = CMD_START_DEF,
  parameter logic [CMD_W-1:0] CMD_STOP  = CMD_STOP_DEF,
  parameter bit               ONESHOT   = 1'b0,
  parameter int unsigned      TIMEOUT   = 1000,
  parameter int unsigned      TO_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_data_fresh,
  input  logic [CMD_W-1:0]   rx_data,
  input  logic [N_TASKS-1:0] task_en,
  input  logic [N_TASKS-1:0] done,
  output logic [N_TASKS-1:0] grant,
  output logic [IDX_W-1:0]   cur_task,
  output logic               led,
  output logic               timeout_flag
);

  state_t               state_q, state_nxt;
  logic [IDX_W-1:0]     cur_q, cur_nxt;
  logic                 stop_q, stop_nxt;
  logic                 flag_q, flag_nxt;
  logic                 fresh_q;
  logic [N_TASKS-1:0]   grant_q, grant_nxt;
  logic                 led_q, led_nxt;

  logic [MAX_TASKS-1:0] en_c;
  logic                 new_cmd_c, cmd_start_c, cmd_stop_c;
  logic                 done_hit_c, expired_c;
  sel_t                 next_c;

  // Lowest enabled index strictly above cur, else wrap to the lowest enabled index.
  function automatic sel_t next_sel(input logic [MAX_TASKS-1:0] en, input logic [IDX_W-1:0] cur);
    sel_t s;
    s.found = |en;
    s.wrap  = 1'b1;
    s.idx   = lowest_set(en);
    for (int i = MAX_TASKS - 1; i >= 0; i--) begin
      if (en[i] && (IDX_W'(i) > cur)) begin
        s.wrap = 1'b0;
        s.idx  = IDX_W'(i);
      end
    end
    return s;
  endfunction

  assign en_c        = MAX_TASKS'(task_en);
  assign new_cmd_c   = rx_data_fresh && !fresh_q;
  assign cmd_start_c = new_cmd_c && (rx_data == CMD_START);
  assign cmd_stop_c  = new_cmd_c && (rx_data == CMD_STOP);
  assign done_hit_c  = |(grant_q & done);
  assign next_c      = next_sel(en_c, cur_q);

  task_sequencer_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .clear     (state_q != ST_GRANT),
    .enable    (state_q == ST_GRANT),
    .expired_c (expired_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    cur_nxt   = cur_q;
    stop_nxt  = stop_q;
    flag_nxt  = flag_q;
    if (cmd_stop_c && (state_q != ST_IDLE)) stop_nxt = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (cmd_start_c) begin
          flag_nxt = 1'b0;
          stop_nxt = 1'b0;
          if (|en_c) begin
            cur_nxt   = lowest_set(en_c);
            state_nxt = ST_SELECT;
          end
        end
      end
      ST_SELECT: state_nxt = ST_GRANT;
      ST_GRANT: begin
        // done wins a tie with expiry, so the flag only marks genuine stalls
        if (done_hit_c) begin
          state_nxt = ST_GAP;
        end else if (expired_c) begin
          flag_nxt  = 1'b1;
          state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        if (stop_q || !next_c.found || (ONESHOT && next_c.wrap)) begin
          stop_nxt  = 1'b0;
          state_nxt = ST_IDLE;
        end else begin
          cur_nxt   = next_c.idx;
          state_nxt = ST_SELECT;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    grant_nxt = '0;
    led_nxt   = (state_nxt != ST_IDLE);
    for (int i = 0; i < N_TASKS; i++) begin
      grant_nxt[i] = (state_nxt == ST_GRANT) && (cur_nxt == IDX_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q   <= '0;
      stop_q  <= 1'b0;
      flag_q  <= 1'b0;
      fresh_q <= 1'b0;
      grant_q <= '0;
      led_q   <= 1'b0;
    end else begin
      cur_q   <= cur_nxt;
      stop_q  <= stop_nxt;
      flag_q  <= flag_nxt;
      fresh_q <= rx_data_fresh;
      grant_q <= grant_nxt;
      led_q   <= led_nxt;
    end
  end

  assign grant        = grant_q;
  assign cur_task     = cur_q;
  assign led          = led_q;
  assign timeout_flag = flag_q;

endmodule

// File: tb/tb_task_sequencer.sv
// Bench for task_sequencer: a continuous 4-channel instance with a short watchdog
// and a one-shot 3-channel instance with the watchdog disarmed.
module tb_task_sequencer;

  localparam int TIMEOUT_A = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       fresh_a, fresh_b;
  logic [7:0] rx;
  logic [3:0] en_a, done_a, grant_a;
  logic [2:0] en_b, done_b, grant_b;
  logic [2:0] cur_a, cur_b;
  logic       led_a, led_b, flag_a, flag_b;

  bit sel;
  bit hold_fresh;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  task_sequencer #(.N_TASKS(4), .ONESHOT(1'b0), .TIMEOUT(TIMEOUT_A), .TO_W(4)) u_a (
    .clk(clk), .rst(rst), .rx_data_fresh(fresh_a), .rx_data(rx), .task_en(en_a),
    .done(done_a), .grant(grant_a), .cur_task(cur_a), .led(led_a), .timeout_flag(flag_a));

  task_sequencer #(.N_TASKS(3), .ONESHOT(1'b1), .TIMEOUT(0), .TO_W(8)) u_b (
    .clk(clk), .rst(rst), .rx_data_fresh(fresh_b), .rx_data(rx), .task_en(en_b),
    .done(done_b), .grant(grant_b), .cur_task(cur_b), .led(led_b), .timeout_flag(flag_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Next enabled channel after cur in rotating order; -1 when none enabled.
  function automatic int next_en(input logic [7:0] en, input int cur, input int n);
    for (int d = 1; d <= n; d++) begin
      if (en[(cur + d) % n]) return (cur + d) % n;
    end
    return -1;
  endfunction

  function automatic logic [31:0] v_grant();
    return sel ? 32'(grant_b) : 32'(grant_a);
  endfunction
  function automatic logic [31:0] v_cur();
    return sel ? 32'(cur_b) : 32'(cur_a);
  endfunction
  function automatic logic [31:0] v_led();
    return sel ? 32'(led_b) : 32'(led_a);
  endfunction
  function automatic logic [31:0] v_flag();
    return sel ? 32'(flag_b) : 32'(flag_a);
  endfunction

  task automatic set_done(input logic [7:0] v);
    if (sel) done_b = v[2:0];
    else     done_a = v[3:0];
  endtask

  task automatic send_cmd(input logic [7:0] b);
    rx = b;
    if (sel) fresh_b = 1'b1;
    else     fresh_a = 1'b1;
  endtask

  // One clock; commands last a single edge unless held. Grant must stay one-hot or zero.
  task automatic tick();
    @(posedge clk);
    #1;
    if (!hold_fresh) begin
      fresh_a = 1'b0;
      fresh_b = 1'b0;
    end
    chk("onehot_a", 32'($countones(grant_a) <= 1), 1);
    chk("onehot_b", 32'($countones(grant_b) <= 1), 1);
  endtask

  task automatic start_cmd();
    send_cmd(8'd98);
    tick();
    chk("start_led", v_led(), 1);
    chk("start_grant_low", v_grant(), 0);
    chk("start_flag_clear", v_flag(), 0);
    tick();
  endtask

  // Entered just after grant rises; answers after d cycles (d=0: never) and
  // returns two edges after the drop, where the next grant is due.
  task automatic serve(input int ch, input int d);
    logic [7:0] mine;
    mine = 8'(1) << ch;
    chk("grant", v_grant(), 32'(mine));
    chk("cur_task", v_cur(), 32'(ch));
    chk("led_run", v_led(), 1);
    if (d == 0) begin
      repeat (TIMEOUT_A - 1) begin
        set_done(8'($urandom) & ~mine);
        tick();
      end
      chk("grant_hold", v_grant(), 32'(mine));
      set_done(8'($urandom) & ~mine);
      tick();
      set_done(8'h00);
      chk("grant_timeout_drop", v_grant(), 0);
    end else begin
      repeat (d - 1) begin
        set_done(8'($urandom) & ~mine);
        tick();
      end
      chk("grant_hold", v_grant(), 32'(mine));
      set_done(8'($urandom) | mine);
      tick();
      set_done(8'h00);
      chk("grant_done_drop", v_grant(), 0);
    end
    tick();
    chk("grant_gap", v_grant(), 0);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit: observed timeout expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    int exp_ch;
    int d;
    int r;
    bit exp_flag;

    rst = 1'b1; fresh_a = 1'b0; fresh_b = 1'b0; rx = 8'h00;
    en_a = 4'h0; done_a = 4'h0; en_b = 3'h0; done_b = 3'h0;
    sel = 1'b0; hold_fresh = 1'b0; exp_flag = 1'b0;
    tick();
    tick();
    chk("rst_grant_a", 32'(grant_a), 0);
    chk("rst_cur_a", 32'(cur_a), 0);
    chk("rst_led_a", 32'(led_a), 0);
    chk("rst_flag_a", 32'(flag_a), 0);
    chk("rst_grant_b", 32'(grant_b), 0);
    chk("rst_led_b", 32'(led_b), 0);
    rst = 1'b0;
    tick();

    // Start with nothing enabled stays idle; a start held high never fires twice.
    hold_fresh = 1'b1;
    send_cmd(8'd98);
    tick();
    chk("start_no_en_idle", 32'(led_a), 0);
    en_a = 4'b0011;
    repeat (4) tick();
    chk("held_fresh_once", 32'(led_a), 0);
    hold_fresh = 1'b0;
    fresh_a = 1'b0;
    tick();

    // Stop while idle must not linger as a pending stop.
    send_cmd(8'd115);
    tick();
    tick();

    start_cmd();
    exp_ch = 0;
    for (int it = 0; it < 30; it++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      d = 0;
      else if (r == 1) d = TIMEOUT_A;
      else             d = int'($urandom_range(1, TIMEOUT_A - 1));
      if (it % 4 == 3) en_a = 4'($urandom_range(1, 15));
      if (it == 10) send_cmd(8'd98);
      serve(exp_ch, d);
      if (d == 0) exp_flag = 1'b1;
      chk("timeout_flag", 32'(flag_a), 32'(exp_flag));
      exp_ch = next_en(8'(en_a), exp_ch, 4);
    end

    // Forced stall, then a start while running must neither restart nor clear the flag.
    serve(exp_ch, 0);
    chk("flag_after_timeout", 32'(flag_a), 1);
    exp_ch = next_en(8'(en_a), exp_ch, 4);
    send_cmd(8'd98);
    serve(exp_ch, 2);
    chk("flag_kept_on_restart", 32'(flag_a), 1);
    exp_ch = next_en(8'(en_a), exp_ch, 4);

    // Stop during a grant: that task completes, then the sequencer idles.
    send_cmd(8'd115);
    serve(exp_ch, 3);
    chk("stop_idle_grant", 32'(grant_a), 0);
    chk("stop_idle_led", 32'(led_a), 0);
    repeat (4) tick();
    chk("stop_no_regrant", 32'(grant_a), 0);
    chk("flag_sticky_idle", 32'(flag_a), 1);
    chk("cur_last_granted", 32'(cur_a), 32'(exp_ch));
    send_cmd(8'd115);
    tick();
    tick();

    // Sparse enables, then a single channel regranted, then reset mid-grant.
    en_a = 4'b1010;
    start_cmd();
    serve(1, 2);
    serve(3, 2);
    en_a = 4'b0100;
    serve(1, 2);
    serve(2, 1);
    serve(2, 0);
    chk("flag_single_timeout", 32'(flag_a), 1);
    chk("regrant_same", 32'(grant_a), 32'(4'b0100));
    rst = 1'b1;
    tick();
    chk("rst_mid_grant", 32'(grant_a), 0);
    chk("rst_mid_led", 32'(led_a), 0);
    chk("rst_mid_cur", 32'(cur_a), 0);
    chk("rst_mid_flag", 32'(flag_a), 0);
    rst = 1'b0;
    en_a = 4'b1111;
    tick();
    start_cmd();
    serve(0, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // One-shot instance: each channel once, watchdog disarmed, then idle.
    sel = 1'b1;
    en_b = 3'b111;
    start_cmd();
    serve(0, 40);
    chk("oneshot_no_flag", 32'(flag_b), 0);
    serve(1, 3);
    serve(2, 1);
    chk("oneshot_idle_grant", 32'(grant_b), 0);
    chk("oneshot_idle_led", 32'(led_b), 0);
    repeat (5) tick();
    chk("oneshot_stays_idle", 32'(grant_b), 0);
    chk("oneshot_cur_last", 32'(cur_b), 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
